// File: rtl/hs4_rx_sync.sv
// hs4_rx_sync: clocked receiver for a 4-phase (return-to-zero) request/ack
// handshake. The request is synchronised into clk_i, the bundled data word
// is captured into a small FIFO, and the FIFO head is offered downstream on
// a valid/ready interface.
module hs4_rx_sync #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic                       ack_o,
   output logic                       valid_o,
   output logic [DATA_W-1:0]          data_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ARM   = 2'd0,
      IDLE  = 2'd1,
      ACKED = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Request synchroniser
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;

   // Shift raw req_i through the synchroniser chain; resets to all ones so a
   // request left high across reset is seen as still asserted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // FIFO bookkeeping signals
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              push;
   logic              pop;
   logic              space_ok;

   assign valid_o  = (count_q != '0);
   assign pop      = valid_o & ready_i;
   // A full FIFO still has room when the head leaves at the same edge.
   assign space_ok = (count_q < DEPTH_C) || ((count_q == DEPTH_C) && pop);

   // ------------------------------------------------------------------
   // Handshake FSM
   // ------------------------------------------------------------------
   state_t state_q;
   state_t state_d;
   logic   ack_q;
   logic   ack_d;

   // State and acknowledge registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARM;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state decode; the FIFO write is issued on the IDLE->ACKED capture.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         ARM: begin
            if (!req_s) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (req_s && space_ok) begin
               push    = 1'b1;
               state_d = ACKED;
            end
         end
         ACKED: begin
            if (!req_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = ARM;
         end
      endcase
      ack_d = (state_d == ACKED);
   end

   assign ack_o = ack_q;

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : PTR_W'(p + 1'b1);
   endfunction

   // Storage array; stale contents are harmless because occupancy gates valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointer and occupancy update; push and pop together leave count unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count_o = count_q;
   // Head word is zero while empty so reset and idle present a clean bus.
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_hs4_rx_sync.sv
// tb_hs4_rx_sync: randomized self-checking bench for hs4_rx_sync.
module tb_hs4_rx_sync;

   localparam int DATA_W      = 32;
   localparam int DEPTH       = 2;
   localparam int SYNC_STAGES = 2;
   localparam int CW          = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_i;
   logic              req_i;
   logic [DATA_W-1:0] data_i;
   logic              ack_o;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic              ready_i;
   logic [CW-1:0]     count_o;

   int checks   = 0;
   int failures = 0;

   // Reference FIFO contents, words seen leaving the DUT, and words sent.
   logic [DATA_W-1:0] model_q[$];
   logic [DATA_W-1:0] got_q[$];
   logic [DATA_W-1:0] sent_q[$];
   int                cnt_bad;
   int                max_cnt;
   int                ready_mode;   // 0 hold, 1 toggle each cycle, 2 random

   always #5 clk = ~clk;

   hs4_rx_sync #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .data_i  (data_i),
      .ack_o   (ack_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .ready_i (ready_i),
      .count_o (count_o)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock (negedge to negedge) and update the queue model.
   task automatic step();
      logic pop_now;
      logic was_rst;
      logic ack_prev;
      logic [CW-1:0] exp_c;
      pop_now  = (model_q.size() != 0) && (ready_i === 1'b1) && (rst_i === 1'b0);
      was_rst  = rst_i;
      ack_prev = ack_o;
      if (pop_now) got_q.push_back(data_o);
      @(negedge clk);
      if (was_rst === 1'b1) begin
         model_q.delete();
      end else begin
         if (pop_now) void'(model_q.pop_front());
         if (ack_o === 1'b1 && ack_prev === 1'b0) model_q.push_back(data_i);
      end
      exp_c = CW'(model_q.size());
      if (count_o !== exp_c) cnt_bad++;
      if (valid_o !== (model_q.size() != 0)) cnt_bad++;
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      case (ready_mode)
         1:       ready_i = ~ready_i;
         2:       ready_i = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   // One full 4-phase handshake with bounded waits; 'to' flags a timeout.
   task automatic xfer(input logic [DATA_W-1:0] d, output bit to);
      int n;
      to     = 1'b0;
      data_i = d;
      req_i  = 1'b1;
      n      = 0;
      while (ack_o !== 1'b1 && n < 60) begin step(); n++; end
      if (ack_o !== 1'b1) to = 1'b1;
      req_i = 1'b0;
      n     = 0;
      while (ack_o !== 1'b0 && n < 60) begin step(); n++; end
      if (ack_o !== 1'b0) to = 1'b1;
      data_i = $urandom;
   endtask

   task automatic drain();
      int n;
      ready_mode = 0;
      ready_i    = 1'b1;
      n          = 0;
      while (model_q.size() != 0 && n < 30) begin step(); n++; end
      step();
      ready_i = 1'b0;
   endtask

   task automatic start_scenario();
      got_q.delete();
      sent_q.delete();
      cnt_bad = 0;
      max_cnt = 0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; req_i = 1'b0; ready_i = 1'b0; data_i = '0; ready_mode = 0;
      start_scenario();
      repeat (3) step();
      checks++;
      if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
      checks++;
      if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
      checks++;
      if (count_o !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      checks++;
      if (data_o !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", data_o); end
      rst_i = 1'b0;
      repeat (5) step();
      checks++;
      if ({ack_o, valid_o, count_o} !== '0) begin
         failures++; $display("FAIL reset_release: got ack=%b valid=%b count=%0d expected all 0", ack_o, valid_o, count_o);
      end
   endtask

   task automatic test_single();
      start_scenario();
      ready_mode = 0; ready_i = 1'b0;
      data_i = 32'hDEADBEEF;
      req_i  = 1'b1;
      step(); step();
      checks++;
      if ({ack_o, valid_o} !== 2'b00) begin
         failures++; $display("FAIL single_early: got ack=%b valid=%b expected 0 0 before edge 2", ack_o, valid_o);
      end
      step();
      checks++;
      if ({ack_o, valid_o} !== 2'b11) begin
         failures++; $display("FAIL single_ack_edge2: got ack=%b valid=%b expected 1 1", ack_o, valid_o);
      end
      checks++;
      if (data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h expected deadbeef", data_o); end
      checks++;
      if (count_o !== CW'(1)) begin failures++; $display("FAIL single_count: got %0d expected 1", count_o); end
      req_i = 1'b0;
      step(); step();
      checks++;
      if (ack_o !== 1'b1) begin failures++; $display("FAIL single_release_early: got %b expected 1", ack_o); end
      step();
      checks++;
      if (ack_o !== 1'b0) begin failures++; $display("FAIL single_release: got %b expected 0", ack_o); end
      drain();
      checks++;
      if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEEF) begin
         failures++; $display("FAIL single_pop: got %0d words first=%h expected 1 word deadbeef", got_q.size(), (got_q.size() != 0) ? got_q[0] : '0);
      end
      checks++;
      if (cnt_bad != 0) begin failures++; $display("FAIL single_count_track: got %0d bad cycles expected 0", cnt_bad); end
   endtask

   task automatic test_fill_stall();
      bit to1, to2;
      int stall_bad, n, bad;
      start_scenario();
      ready_mode = 0; ready_i = 1'b0;
      xfer(DATA_W'(1), to1);
      xfer(DATA_W'(2), to2);
      checks++;
      if (to1 || to2) begin failures++; $display("FAIL fill_timeout: got timeouts %b%b expected 00", to1, to2); end
      checks++;
      if (count_o !== CW'(2)) begin failures++; $display("FAIL fill_count: got %0d expected 2", count_o); end
      data_i = DATA_W'(3);
      req_i  = 1'b1;
      stall_bad = 0;
      repeat (10) begin step(); if (ack_o !== 1'b0) stall_bad++; end
      checks++;
      if (stall_bad != 0) begin failures++; $display("FAIL stall_ack: got %0d cycles with ack expected 0", stall_bad); end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      checks++;
      if ({ack_o, count_o} !== {1'b1, CW'(2)}) begin
         failures++; $display("FAIL stall_release: got ack=%b count=%0d expected ack=1 count=2", ack_o, count_o);
      end
      req_i = 1'b0;
      n = 0;
      while (ack_o !== 1'b0 && n < 20) begin step(); n++; end
      checks++;
      if (ack_o !== 1'b0) begin failures++; $display("FAIL stall_ack_drop: got %b expected 0 within bound", ack_o); end
      drain();
      sent_q = '{DATA_W'(1), DATA_W'(2), DATA_W'(3)};
      bad = (got_q.size() != sent_q.size()) ? 1 : 0;
      if (bad == 0) foreach (sent_q[i]) if (got_q[i] !== sent_q[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL stall_order: got %0d words, %0d mismatched, expected 1,2,3", got_q.size(), bad); end
      checks++;
      if (cnt_bad != 0) begin failures++; $display("FAIL stall_count_track: got %0d bad cycles expected 0", cnt_bad); end
   endtask

   task automatic test_streaming();
      bit to;
      int tos, bad;
      start_scenario();
      ready_mode = 0; ready_i = 1'b1;
      tos = 0;
      for (int i = 0; i < 8; i++) begin
         sent_q.push_back(DATA_W'(i));
         xfer(DATA_W'(i), to);
         if (to) tos++;
         repeat ($urandom_range(0, 2)) step();
      end
      repeat (4) step();
      ready_i = 1'b0;
      checks++;
      if (tos != 0) begin failures++; $display("FAIL stream_timeout: got %0d timeouts expected 0", tos); end
      bad = (got_q.size() != sent_q.size()) ? 1 : 0;
      if (bad == 0) foreach (sent_q[i]) if (got_q[i] !== sent_q[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL stream_order: got %0d words, %0d mismatched, expected 0..7", got_q.size(), bad); end
      checks++;
      if (max_cnt > 1) begin failures++; $display("FAIL stream_max_count: got %0d expected <=1", max_cnt); end
      checks++;
      if (cnt_bad != 0) begin failures++; $display("FAIL stream_count_track: got %0d bad cycles expected 0", cnt_bad); end
   endtask

   task automatic test_wrap();
      bit to;
      int tos, bad;
      logic [DATA_W-1:0] w;
      start_scenario();
      ready_i = 1'b0; ready_mode = 1;
      tos = 0;
      for (int i = 0; i < 5; i++) begin
         w = $urandom;
         sent_q.push_back(w);
         xfer(w, to);
         if (to) tos++;
      end
      drain();
      checks++;
      if (tos != 0) begin failures++; $display("FAIL wrap_timeout: got %0d timeouts expected 0", tos); end
      bad = (got_q.size() != sent_q.size()) ? 1 : 0;
      if (bad == 0) foreach (sent_q[i]) if (got_q[i] !== sent_q[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL wrap_order: got %0d words, %0d mismatched, expected 5 in order", got_q.size(), bad); end
      checks++;
      if (cnt_bad != 0 || max_cnt > DEPTH) begin
         failures++; $display("FAIL wrap_count_track: got %0d bad cycles max %0d expected 0 and <=%0d", cnt_bad, max_cnt, DEPTH);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int n, bad_ack;
      start_scenario();
      ready_mode = 0; ready_i = 1'b0;
      data_i = $urandom;
      req_i  = 1'b1;
      n = 0;
      while (ack_o !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (ack_o !== 1'b1) begin failures++; $display("FAIL rstmid_enter: got ack=%b expected 1", ack_o); end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      checks++;
      if ({ack_o, valid_o, count_o} !== '0) begin
         failures++; $display("FAIL rstmid_clear: got ack=%b valid=%b count=%0d expected all 0", ack_o, valid_o, count_o);
      end
      bad_ack = 0;
      repeat (10) begin step(); if (ack_o !== 1'b0 || count_o !== '0) bad_ack++; end
      checks++;
      if (bad_ack != 0) begin failures++; $display("FAIL rstmid_no_recapture: got %0d bad cycles expected 0", bad_ack); end
      req_i = 1'b0;
      repeat (4) step();
      xfer(DATA_W'(32'hA5), to);
      checks++;
      if (to) begin failures++; $display("FAIL rstmid_timeout: got timeout expected capture"); end
      checks++;
      if (data_o !== DATA_W'(32'hA5) || count_o !== CW'(1)) begin
         failures++; $display("FAIL rstmid_capture: got data=%h count=%0d expected a5 1", data_o, count_o);
      end
      drain();
      checks++;
      if (got_q.size() != 1 || cnt_bad != 0) begin
         failures++; $display("FAIL rstmid_track: got %0d words %0d bad cycles expected 1 0", got_q.size(), cnt_bad);
      end
   endtask

   task automatic test_idle_pop();
      bit to1, to2;
      int bad;
      logic [DATA_W-1:0] w1, w2;
      start_scenario();
      ready_mode = 0; ready_i = 1'b1;
      bad = 0;
      repeat (10) begin step(); if (count_o !== '0 || valid_o !== 1'b0) bad++; end
      ready_i = 1'b0;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL idle_pop: got %0d bad cycles expected 0", bad); end
      w1 = $urandom; w2 = $urandom;
      xfer(w1, to1);
      checks++;
      if (data_o !== w1) begin failures++; $display("FAIL idle_head: got %h expected %h", data_o, w1); end
      xfer(w2, to2);
      checks++;
      if (to1 || to2 || data_o !== w1 || count_o !== CW'(2)) begin
         failures++; $display("FAIL idle_second: got data=%h count=%0d expected %h 2", data_o, count_o, w1);
      end
      drain();
      checks++;
      if (got_q.size() != 2 || got_q[0] !== w1 || got_q[1] !== w2 || cnt_bad != 0) begin
         failures++; $display("FAIL idle_order: got %0d words %0d bad cycles expected %h,%h", got_q.size(), cnt_bad, w1, w2);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_stall();
      test_streaming();
      test_wrap();
      test_reset_mid();
      test_idle_pop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
